button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_DEBOUNCE, default 1000000, consecutive stable synchronized cycles required to accept a press or release; legal range >= 2.
REQ-002 Parameter N_REPEAT, default 25000000, held-button auto-repeat spacing control; legal range >= 2.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 btn  input  4  raw, unsynchronized, bouncing push-button levels, one bit per channel.
REQ-006 DPBs  output  4  debounced button level per channel.
REQ-007 SCENs  output  4  single-clock enable: exactly one 1-cycle pulse per accepted press.
REQ-008 MCENs  output  4  multiple-clock enable: pulse on press, then periodic pulses while held.

Function
REQ-009 Each channel SHALL be an independent, identical instance of the logic below; channels share no state.
REQ-010 Each btn bit SHALL pass through a 2-flop synchronizer; the FSM samples only the second flop (sync).
REQ-011 Per-channel FSM states SHALL be IDLE, DEB_PRESS, PULSE, HELD, REPEAT, DEB_RELEASE.
REQ-012 Each channel SHALL have a debounce counter of $clog2(N_DEBOUNCE) bits and a repeat counter of $clog2(N_REPEAT) bits, never wrapping past their terminal values.
REQ-013 IDLE: sync=1 -> DEB_PRESS with debounce counter cleared; else remain.
REQ-014 DEB_PRESS: sync=0 -> IDLE; sync=1 and counter=N_DEBOUNCE-1 -> PULSE; otherwise counter increments.
REQ-015 PULSE: unconditionally -> HELD with repeat counter cleared, regardless of sync.
REQ-016 HELD: sync=0 -> DEB_RELEASE with debounce counter cleared; sync=1 and repeat counter=N_REPEAT-1 -> REPEAT; otherwise repeat counter increments.
REQ-017 REPEAT: unconditionally -> HELD with repeat counter cleared.
REQ-018 DEB_RELEASE: sync=1 -> HELD with repeat counter cleared, no new SCEN; sync=0 and counter=N_DEBOUNCE-1 -> IDLE; otherwise counter increments.
REQ-019 Outputs SHALL be Moore-decoded from registered state, glitch-free: SCENs=PULSE; MCENs=PULSE or REPEAT; DPBs=PULSE, HELD, REPEAT or DEB_RELEASE.
REQ-020 Latency: with btn rising before edge 1 and stable, PULSE (SCENs, MCENs, DPBs high) SHALL begin at edge N_DEBOUNCE+3.
REQ-021 MCENs pulses while held SHALL be spaced exactly N_REPEAT+1 cycles apart, first repeat N_REPEAT+1 cycles after the PULSE cycle.
REQ-022 Release: with btn falling before edge 1 in HELD and staying low, DPBs SHALL fall at edge N_DEBOUNCE+3.
REQ-023 A bounce shorter than N_DEBOUNCE synchronized cycles SHALL produce no output change in either direction.
REQ-024 At most one SCENs pulse per accepted press; a release glitch never re-triggers SCENs.

Reset
REQ-025 reset=1 SHALL immediately, without clock, force all states to IDLE, synchronizer flops and counters to 0, and DPBs, SCENs, MCENs to 4'b0000.
REQ-026 After reset deassertion, a button already held SHALL be treated as a new press with REQ-020 latency counted from the first post-reset edge.

Verification (N_DEBOUNCE=4, N_REPEAT=8)
REQ-027 btn[0] rises before edge 1, held 40 cycles -> SCENs[0] high only at edge 7 cycle; DPBs[0] high from edge 7; MCENs[0] pulses at edges 7, 16, 25, 34; other channels 0.
REQ-028 btn[1] high for 3 cycles (edges 1-3) then low -> DPBs, SCENs, MCENs stay 0 throughout.
REQ-029 btn[2] held to HELD, then low 2 cycles, then high again -> DPBs[2] stays 1, no SCENs pulse; subsequent clean release drops DPBs[2] at release edge 7.
REQ-030 btn=4'b1111 rising together before edge 1 -> SCENs=4'b1111 in the same single cycle at edge 7.
REQ-031 reset asserted mid-clock while btn[3] held and DPBs[3]=1 -> all outputs 0 before next edge; deassert with btn[3] still high -> SCENs[3] pulse at post-reset edge 7.

Source files
------------

// File: rtl/button_conditioner_if.sv
// -----------------------------------------------------------------------------
// button_conditioner_if
// Four-channel push-button bus between a button source and the conditioner.
//   btn   : raw, unsynchronized, bouncing button levels (one bit per channel)
//   DPBs  : debounced button level per channel
//   SCENs : one 1-cycle pulse per accepted press
//   MCENs : pulse on press, then periodic pulses while the button is held
// master drives btn and observes the outputs; slave is the conditioner side.
// -----------------------------------------------------------------------------
interface button_conditioner_if;
    logic [3:0] btn;
    logic [3:0] DPBs;
    logic [3:0] SCENs;
    logic [3:0] MCENs;

    modport master (output btn, input  DPBs, SCENs, MCENs);
    modport slave  (input  btn, output DPBs, SCENs, MCENs);
endinterface

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Four independent push-button conditioners: 2-flop synchronizer, debounce on
// press and release, single-shot press pulse and auto-repeat pulse while held.
// Ports:
//   clk   : system clock, all state changes on rising edge
//   reset : asynchronous active-high reset
//   bus   : button_conditioner_if.slave (btn in; DPBs, SCENs, MCENs out)
// -----------------------------------------------------------------------------

// One conditioner channel.
//   i_btn  : raw button level
//   o_dpb  : debounced level
//   o_scen : press pulse
//   o_mcen : press pulse plus auto-repeat pulses
module button_conditioner_ch #(
    parameter int N_DEBOUNCE = 1000000,
    parameter int N_REPEAT   = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_dpb,
    output logic o_scen,
    output logic o_mcen
);
    localparam int DW = $clog2(N_DEBOUNCE);
    localparam int RW = $clog2(N_REPEAT);
    localparam logic [DW-1:0] DEB_LAST = DW'(N_DEBOUNCE - 1);
    localparam logic [RW-1:0] REP_LAST = RW'(N_REPEAT - 1);

    typedef enum logic [2:0] {
        IDLE, DEB_PRESS, PULSE, HELD, REPEAT, DEB_RELEASE
    } state_t;

    logic          r_meta, r_sync;
    state_t        r_state, w_state_nxt;
    logic [DW-1:0] r_deb_cnt, w_deb_nxt;
    logic [RW-1:0] r_rep_cnt, w_rep_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta    <= 1'b0;
            r_sync    <= 1'b0;
            r_state   <= IDLE;
            r_deb_cnt <= '0;
            r_rep_cnt <= '0;
        end else begin
            r_meta    <= i_btn;
            r_sync    <= r_meta;
            r_state   <= w_state_nxt;
            r_deb_cnt <= w_deb_nxt;
            r_rep_cnt <= w_rep_nxt;
        end
    end

    // Counters only advance up to their terminal value: the terminal compare
    // always moves the FSM on before another increment could wrap.
    always_comb begin
        w_state_nxt = r_state;
        w_deb_nxt   = r_deb_cnt;
        w_rep_nxt   = r_rep_cnt;
        unique case (r_state)
            IDLE: begin
                if (r_sync) begin
                    w_state_nxt = DEB_PRESS;
                    w_deb_nxt   = '0;
                end
            end
            DEB_PRESS: begin
                if (!r_sync)                    w_state_nxt = IDLE;
                else if (r_deb_cnt == DEB_LAST) w_state_nxt = PULSE;
                else                            w_deb_nxt   = r_deb_cnt + 1'b1;
            end
            PULSE, REPEAT: begin
                w_state_nxt = HELD;
                w_rep_nxt   = '0;
            end
            HELD: begin
                if (!r_sync) begin
                    w_state_nxt = DEB_RELEASE;
                    w_deb_nxt   = '0;
                end else if (r_rep_cnt == REP_LAST) begin
                    w_state_nxt = REPEAT;
                end else begin
                    w_rep_nxt   = r_rep_cnt + 1'b1;
                end
            end
            DEB_RELEASE: begin
                // A return to high is a release glitch: resume holding
                // without a new press pulse.
                if (r_sync) begin
                    w_state_nxt = HELD;
                    w_rep_nxt   = '0;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_deb_nxt   = r_deb_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Moore decode of the registered state keeps the outputs glitch-free.
    assign o_scen = (r_state == PULSE);
    assign o_mcen = (r_state == PULSE) || (r_state == REPEAT);
    assign o_dpb  = (r_state == PULSE) || (r_state == HELD) ||
                    (r_state == REPEAT) || (r_state == DEB_RELEASE);
endmodule

module button_conditioner #(
    parameter int N_DEBOUNCE = 1000000,
    parameter int N_REPEAT   = 25000000
) (
    input  logic                        clk,
    input  logic                        reset,
    button_conditioner_if.slave         bus
);
    localparam int NUM_CH = 4;

    logic [NUM_CH-1:0] w_dpb, w_scen, w_mcen;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        button_conditioner_ch #(
            .N_DEBOUNCE (N_DEBOUNCE),
            .N_REPEAT   (N_REPEAT)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .i_btn  (bus.btn[g]),
            .o_dpb  (w_dpb[g]),
            .o_scen (w_scen[g]),
            .o_mcen (w_mcen[g])
        );
    end

    assign bus.DPBs  = w_dpb;
    assign bus.SCENs = w_scen;
    assign bus.MCENs = w_mcen;
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with N_DEBOUNCE=4, N_REPEAT=8. Directed
// scenarios plus random bouncing stimulus, all checked against a run-length
// reference model of the accept / repeat / release rules.
module tb_button_conditioner;
    localparam int ND = 4;
    localparam int NR = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    button_conditioner_if bif ();

    button_conditioner #(.N_DEBOUNCE(ND), .N_REPEAT(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // acc  : accepted (debounced) level
    // run  : consecutive edges the synchronized input has read high while not accepted
    // rel  : consecutive low edges since a release started (0 = not releasing)
    // t    : edges since the last press/repeat pulse or since holding resumed
    // pend : previous edge emitted a press/repeat pulse (input ignored this edge)
    bit       m_s1[4], m_s2[4], m_acc[4], m_pend[4];
    int       m_run[4], m_rel[4], m_t[4];
    logic [3:0] e_dpb, e_scen, e_mcen;

    function automatic void m_reset();
        for (int c = 0; c < 4; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_acc[c] = 0; m_pend[c] = 0;
            m_run[c] = 0; m_rel[c] = 0; m_t[c] = 0;
        end
        e_dpb = '0; e_scen = '0; e_mcen = '0;
    endfunction

    function automatic void m_step(input logic [3:0] btn);
        bit s;
        for (int c = 0; c < 4; c++) begin
            s = m_s2[c];
            e_scen[c] = 1'b0;
            e_mcen[c] = 1'b0;
            if (!m_acc[c]) begin
                m_run[c] = s ? m_run[c] + 1 : 0;
                if (m_run[c] == ND + 1) begin
                    m_acc[c] = 1; e_scen[c] = 1'b1; e_mcen[c] = 1'b1;
                    m_t[c] = 0; m_run[c] = 0; m_rel[c] = 0;
                end
            end else if (m_pend[c]) begin
                m_t[c]++;
            end else if (m_rel[c] > 0) begin
                if (s) begin
                    m_rel[c] = 0; m_t[c] = 1;
                end else begin
                    m_rel[c]++;
                    if (m_rel[c] == ND + 1) begin
                        m_acc[c] = 0; m_rel[c] = 0; m_run[c] = 0;
                    end
                end
            end else if (!s) begin
                m_rel[c] = 1;
            end else begin
                m_t[c]++;
                if (m_t[c] == NR + 1) begin
                    e_mcen[c] = 1'b1; m_t[c] = 0;
                end
            end
            m_pend[c] = e_mcen[c];
            e_dpb[c]  = m_acc[c];
            m_s2[c]   = m_s1[c];
            m_s1[c]   = btn[c];
        end
    endfunction

    // One clock: advance the model at the edge, compare shortly after it.
    task automatic tick();
        @(posedge clk);
        m_step(bif.btn);
        #1;
        chk("DPBs",  bif.DPBs,  e_dpb);
        chk("SCENs", bif.SCENs, e_scen);
        chk("MCENs", bif.MCENs, e_mcen);
    endtask

    task automatic do_reset();
        #2;
        reset   = 1'b1;
        bif.btn = 4'b0000;
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    int fall_at, sc_cnt;
    int hold_left[4];

    initial begin
        bif.btn = 4'b0000;
        m_reset();
        #2;
        chk("reset_DPBs",  bif.DPBs,  4'b0000);
        chk("reset_SCENs", bif.SCENs, 4'b0000);
        chk("reset_MCENs", bif.MCENs, 4'b0000);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Single held press: press pulse at edge 7, repeats every 9 edges.
        bif.btn = 4'b0001;
        for (int i = 1; i <= 40; i++) begin
            tick();
            chk("ch0_scen", bif.SCENs, (i == 7) ? 4'b0001 : 4'b0000);
            chk("ch0_mcen", bif.MCENs,
                (i == 7 || i == 16 || i == 25 || i == 34) ? 4'b0001 : 4'b0000);
            chk("ch0_dpb",  bif.DPBs,  (i >= 7) ? 4'b0001 : 4'b0000);
        end

        // Short bounce on channel 1: no output activity at all.
        do_reset();
        bif.btn = 4'b0010;
        for (int i = 1; i <= 20; i++) begin
            if (i == 4) bif.btn = 4'b0000;
            tick();
            chk("bounce_dpb",  bif.DPBs,  4'b0000);
            chk("bounce_scen", bif.SCENs, 4'b0000);
        end

        // Release glitch on channel 2, then a clean release.
        do_reset();
        bif.btn = 4'b0100;
        for (int i = 0; i < 12; i++) tick();
        bif.btn = 4'b0000;
        tick(); tick();
        bif.btn = 4'b0100;
        sc_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("glitch_dpb", bif.DPBs, 4'b0100);
            sc_cnt += int'(bif.SCENs[2]);
        end
        chk("glitch_no_scen", sc_cnt, 0);
        bif.btn = 4'b0000;
        fall_at = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (fall_at == 0 && !bif.DPBs[2]) fall_at = i;
        end
        chk("release_edge", fall_at, 7);

        // All four channels rising together pulse in the same cycle.
        do_reset();
        bif.btn = 4'b1111;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("all_scen", bif.SCENs, (i == 7) ? 4'b1111 : 4'b0000);
        end

        // Async reset mid-cycle while channel 3 is held.
        do_reset();
        bif.btn = 4'b1000;
        for (int i = 0; i < 10; i++) tick();
        chk("pre_reset_dpb", bif.DPBs, 4'b1000);
        #2;
        reset = 1'b1;
        #1;
        chk("async_DPBs",  bif.DPBs,  4'b0000);
        chk("async_SCENs", bif.SCENs, 4'b0000);
        chk("async_MCENs", bif.MCENs, 4'b0000);
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("post_reset_scen", bif.SCENs, (i == 7) ? 4'b1000 : 4'b0000);
        end

        // Random bouncing levels on all channels.
        do_reset();
        for (int c = 0; c < 4; c++) hold_left[c] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 4; c++) begin
                if (hold_left[c] == 0) begin
                    bif.btn[c] = 1'($urandom_range(0, 1));
                    hold_left[c] = ($urandom_range(0, 2) == 0) ?
                                   int'($urandom_range(1, 4)) : int'($urandom_range(5, 40));
                end
                hold_left[c]--;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
